// File: rtl/d_cache.sv
`default_nettype none
// ============================================================================
// d_cache: direct-mapped 16-line, one-word-per-line write-through data cache
// with a 16-cycle invalidate sweep. Optional LOAD hit/miss counters are built
// only when DCACHE_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
module d_cache (
  input  logic        clock,
  input  logic        reset,
  input  logic        state,
  input  logic [15:0] mem_ir,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_dataout,
  input  logic [15:0] d_datain,
  input  logic        flush_req,
  output logic        hit,
  output logic [15:0] cachedata,
  output logic        busy,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_FLUSH  = 1'b1;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;

  logic [0:0]  fsm;
  logic [0:0]  fsm_nxt;
  logic [3:0]  ptr;
  logic [15:0] valid;
  logic [11:0] tags [16];
  logic [15:0] data [16];

  logic [3:0]  idx;
  logic [11:0] addr_tag;
  logic        is_load;
  logic        is_store;
  logic        tag_match;
  logic        fill_en;
  logic        store_en;

  assign idx      = d_addr[3:0];
  assign addr_tag = d_addr[15:4];
  assign is_load  = (mem_ir[15:11] == OP_LOAD);
  assign is_store = (mem_ir[15:11] == OP_STORE);

  // Only the opcode field of the instruction matters here.
  logic unused_ir_bits;
  assign unused_ir_bits = ^mem_ir[10:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm  <= S_IDLE;
      ptr  <= 4'd0;
      busy <= 1'b0;
    end else begin
      fsm  <= fsm_nxt;
      busy <= (fsm_nxt == S_FLUSH);
      // ptr naturally wraps 15 -> 0 on the final sweep cycle
      ptr  <= (fsm == S_FLUSH) ? ptr + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      S_IDLE:  if (state && flush_req) fsm_nxt = S_FLUSH;
      S_FLUSH: if (ptr == 4'hF) fsm_nxt = S_IDLE;
      default: fsm_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tag_match = valid[idx] && (tags[idx] == addr_tag);
    hit       = is_load && (fsm == S_IDLE) && tag_match;
    fill_en   = state && (fsm == S_IDLE) && is_load && !tag_match;
    store_en  = state && (fsm == S_IDLE) && is_store && tag_match;
    cachedata = data[idx];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 16'h0000;
      for (int i = 0; i < 16; i++) begin
        tags[i] <= 12'h000;
        data[i] <= 16'h0000;
      end
    end else if (fsm == S_FLUSH) begin
      valid[ptr] <= 1'b0;
    end else begin
      if (fill_en) begin
        valid[idx] <= 1'b1;
        tags[idx]  <= addr_tag;
        data[idx]  <= d_datain;
      end
      if (store_en) begin
        data[idx] <= d_dataout;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_q;
  logic [15:0] miss_q;

  // A LOAD issued during the sweep sees hit = 0 and is therefore a miss.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_q  <= 16'h0000;
      miss_q <= 16'h0000;
    end else if (state && is_load) begin
      if (hit) hit_q  <= hit_q + 16'd1;
      else     miss_q <= miss_q + 16'd1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = 16'h0000;
  assign miss_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: doc/d_cache.md
D_CACHE -- requirements
Module: d_cache

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately.
REQ-003 state  input  1  CPU run state; 1 = exec, 0 = idle; the cache updates only when 1.
REQ-004 mem_ir  input  16  instruction currently in MEM; opcode = mem_ir[15:11]; LOAD = 5'b00010, STORE = 5'b00011.
REQ-005 d_addr  input  16  word address of the MEM-stage access; tag = d_addr[15:4], index = d_addr[3:0].
REQ-006 d_dataout  input  16  store data driven to data memory.
REQ-007 d_datain  input  16  data-memory read data, valid in the same cycle as d_addr.
REQ-008 flush_req  input  1  request to invalidate every line.
REQ-009 hit  output  1  combinational; current LOAD hits a valid line.
REQ-010 cachedata  output  16  combinational; data word of line d_addr[3:0].
REQ-011 busy  output  1  registered; 1 while the flush sweep runs.
REQ-012 hit_cnt, miss_cnt  output  16 each  LOAD hit and miss counters (see Configuration).

Function
REQ-013 Storage: direct-mapped, 16 lines, each holding valid (1 b), tag (12 b) and data (16 b); one word per line.
REQ-014 hit is 1 only when all of the following hold: opcode == LOAD, FSM in IDLE, valid[idx] == 1, and tag[idx] == d_addr[15:4]; otherwise hit is 0.
REQ-015 cachedata is data[d_addr[3:0]] in every cycle, independent of hit.
REQ-016 LOAD miss in IDLE with state == 1: at the clock edge, write line idx with valid = 1, tag = d_addr[15:4], data = d_datain; the next LOAD to the same address hits.
REQ-017 STORE in IDLE with state == 1: write-through, no-allocate; on a tag match with a valid line, data[idx] <= d_dataout; on a mismatch, no line changes.
REQ-018 Any other opcode, or state == 0: no line, FSM or counter changes, except that a flush sweep in progress continues.
REQ-019 FSM states are IDLE and FLUSH; from reset the FSM is in IDLE.
REQ-020 IDLE -> FLUSH when flush_req == 1 at a clock edge; the access in that cycle is still serviced normally.
REQ-021 FLUSH behaviour:
  - Each cycle, clear valid[ptr] and increment the 4-bit ptr.
  - When ptr == 15, clear that line, return to IDLE, and reset ptr to 0.
  - A sweep lasts exactly 16 cycles; busy = 1 for exactly those 16 cycles.
REQ-022 During FLUSH:
  - hit = 0.
  - No fills occur, and stores do not update lines.
  - flush_req is ignored.
  - The sweep proceeds regardless of state.
REQ-023 Index wrap: ptr wraps 15 -> 0 modulo 16; address wrap needs no special handling.

Reset
REQ-024 While reset is low:
  - All valid bits = 0; tags and data = 0.
  - FSM = IDLE, ptr = 0, busy = 0.
  - hit_cnt = miss_cnt = 0.
REQ-025 Reset asserted mid-flush aborts the sweep; after release the FSM is in IDLE with every line invalid.

Configuration
REQ-026 Macro DCACHE_STATS_EN defined: in IDLE with state == 1, a LOAD hit increments hit_cnt and a LOAD miss increments miss_cnt; both counters wrap modulo 2^16; a LOAD during FLUSH counts as a miss.
REQ-027 Macro DCACHE_STATS_EN undefined: no counter registers exist, and hit_cnt and miss_cnt are tied to 16'h0000.

Verification
REQ-028 Reset, then LOAD d_addr=16'h0012, d_datain=16'hBEEF -> hit=0 in that cycle; a repeat LOAD of 16'h0012 next cycle -> hit=1, cachedata=16'hBEEF.
REQ-029 After REQ-028, LOAD d_addr=16'h0102 (same index 2, different tag), d_datain=16'h1234 -> hit=0, line refilled; LOAD 16'h0012 -> hit=0.
REQ-030 Fill 16'h0005 with 16'hAAAA, then STORE 16'h0005 with d_dataout=16'h5555 -> LOAD 16'h0005 gives hit=1, cachedata=16'h5555; STORE 16'h0305 leaves line 5 unchanged.
REQ-031 Fill all 16 lines, then pulse flush_req -> busy high for exactly 16 cycles; LOADs during the sweep give hit=0; after the sweep, every LOAD misses.
REQ-032 Pull reset low at flush cycle 7 -> busy=0 immediately; after release, FSM is IDLE and no LOAD hits.
REQ-033 With DCACHE_STATS_EN, run 3 hits and 2 misses -> hit_cnt=3, miss_cnt=2; without the macro, both read 0.
